// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator: single outstanding LDUR/STUR request, registered strobes,
// one-cycle-latency read capture and a tagged response with address-error rejection.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int WDATA_W = 32,
  parameter int TAG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [63:0]        req_addr,
  input  logic [WDATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_rdata,
  output logic               resp_write,
  output logic               resp_err,
  output logic [TAG_W-1:0]   resp_tag,
  output logic               read_data_flag,
  output logic               write_data_flag,
  output logic [ADDR_W-1:0]  address_of_data,
  output logic [WDATA_W-1:0] data_to_write,
  input  logic [DATA_W-1:0]  data_read_out,
  output logic [CNT_W-1:0]   load_count,
  output logic [CNT_W-1:0]   store_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t state_reg;
  logic   addr_err;
  logic   accept;

  // Byte address must be doubleword aligned and fall inside the 2^ADDR_W word window.
  assign addr_err  = (req_addr[2:0] != 3'b000) || (req_addr[63:ADDR_W+3] != '0);
  assign req_ready = (state_reg == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_write      <= 1'b0;
      resp_err        <= 1'b0;
      resp_tag        <= '0;
      read_data_flag  <= 1'b0;
      write_data_flag <= 1'b0;
      address_of_data <= '0;
      data_to_write   <= '0;
      load_count      <= '0;
      store_count     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            resp_tag   <= req_tag;
            resp_write <= req_write;
            if (addr_err) begin
              // Rejected requests skip memory entirely and answer next cycle.
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              state_reg  <= RESP;
            end else begin
              resp_err        <= 1'b0;
              address_of_data <= req_addr[ADDR_W+2:3];
              data_to_write   <= req_wdata;
              read_data_flag  <= !req_write;
              write_data_flag <= req_write;
              state_reg       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          read_data_flag  <= 1'b0;
          write_data_flag <= 1'b0;
          if (resp_write) begin
            resp_rdata  <= '0;
            resp_valid  <= 1'b1;
            store_count <= store_count + CNT_W'(1);
            state_reg   <= RESP;
          end else begin
            state_reg <= CAPT;
          end
        end
        CAPT: begin
          // Memory read data is valid the cycle after the read strobe.
          resp_rdata <= data_read_out;
          resp_valid <= 1'b1;
          load_count <= load_count + CNT_W'(1);
          state_reg  <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural 256x64 registered-read memory.
// A second, narrow-counter instance shares the stimulus so counter wrap is reachable quickly.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_write;
  logic        resp_err;
  logic [4:0]  resp_tag;
  logic        read_data_flag;
  logic        write_data_flag;
  logic [7:0]  address_of_data;
  logic [31:0] data_to_write;
  logic [63:0] data_read_out;
  logic [15:0] load_count;
  logic [15:0] store_count;

  logic        w_req_ready;
  logic        w_resp_valid;
  logic [63:0] w_resp_rdata;
  logic        w_resp_write;
  logic        w_resp_err;
  logic [4:0]  w_resp_tag;
  logic        w_read_data_flag;
  logic        w_write_data_flag;
  logic [7:0]  w_address_of_data;
  logic [31:0] w_data_to_write;
  logic [3:0]  w_load_count;
  logic [3:0]  w_store_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [63:0] mem [256];

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_write(resp_write), .resp_err(resp_err), .resp_tag(resp_tag),
    .read_data_flag(read_data_flag), .write_data_flag(write_data_flag),
    .address_of_data(address_of_data), .data_to_write(data_to_write),
    .data_read_out(data_read_out),
    .load_count(load_count), .store_count(store_count)
  );

  dmem_access_ctrl #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(w_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(w_resp_valid), .resp_ready(resp_ready), .resp_rdata(w_resp_rdata),
    .resp_write(w_resp_write), .resp_err(w_resp_err), .resp_tag(w_resp_tag),
    .read_data_flag(w_read_data_flag), .write_data_flag(w_write_data_flag),
    .address_of_data(w_address_of_data), .data_to_write(w_data_to_write),
    .data_read_out(data_read_out),
    .load_count(w_load_count), .store_count(w_store_count)
  );

  // Memory model: writes zero-extend, reads return data one cycle after the strobe.
  always @(posedge clk) begin
    if (write_data_flag) mem[address_of_data] <= {32'h0, data_to_write};
    if (read_data_flag)  data_read_out <= mem[address_of_data];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [63:0] addr, input logic [31:0] wd,
                       input logic [4:0] tag);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_tag   = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] err_addrs [2];
    err_addrs[0] = 64'h31;
    err_addrs[1] = 64'h800;
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    data_read_out = 64'h0;
    reset = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 64'h0; req_wdata = 32'h0; req_tag = 5'h0;
    tick; tick;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rflag", read_data_flag, 0);
    check("rst_wflag", write_data_flag, 0);
    check("rst_addr", address_of_data, 0);
    check("rst_counts", {load_count, store_count}, 0);
    check("rst_req_ready", req_ready, 0);
    reset = 1'b0;
    #1;
    check("idle_req_ready", req_ready, 1);

    // Store 0x30 <- DEADBEEF: strobe one cycle, response two cycles after accept.
    drive(1'b1, 64'h30, 32'hDEADBEEF, 5'd3);
    tick; req_valid = 1'b0;
    check("st_wflag", write_data_flag, 1);
    check("st_rflag", read_data_flag, 0);
    check("st_addr", address_of_data, 6);
    check("st_wdata", data_to_write, 32'hDEADBEEF);
    check("st_busy_valid", resp_valid, 0);
    check("st_busy_ready", req_ready, 0);
    tick;
    check("st_wflag_off", write_data_flag, 0);
    check("st_resp", {resp_valid, resp_err, resp_write, 3'b0, resp_tag}, {3'b101, 3'b0, 5'd3});
    check("st_rdata", resp_rdata, 0);
    check("st_count", store_count, 1);
    tick;
    check("st_done_valid", resp_valid, 0);
    check("st_done_ready", req_ready, 1);

    // Load 0x30: three cycles to response.
    drive(1'b0, 64'h30, 32'h0, 5'd7);
    tick; req_valid = 1'b0;
    check("ld_rflag", read_data_flag, 1);
    check("ld_wflag", write_data_flag, 0);
    check("ld_addr", address_of_data, 6);
    tick;
    check("ld_rflag_off", read_data_flag, 0);
    check("ld_capt_valid", resp_valid, 0);
    tick;
    check("ld_resp", {resp_valid, resp_err, resp_write, 3'b0, resp_tag}, {3'b100, 3'b0, 5'd7});
    check("ld_rdata", resp_rdata, 64'h00000000DEADBEEF);
    check("ld_count", load_count, 1);
    tick;

    // Misaligned and out-of-range addresses answer after one cycle with no access.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, err_addrs[i], 32'h0, 5'(11 + i));
      tick; req_valid = 1'b0;
      check("err_resp", {resp_valid, resp_err, 3'b0, resp_tag}, {2'b11, 3'b0, 5'(11 + i)});
      check("err_strobes", {read_data_flag, write_data_flag}, 0);
      check("err_rdata", resp_rdata, 0);
      check("err_counts", {load_count, store_count}, {16'd1, 16'd1});
      check("err_addr_hold", address_of_data, 6);
      tick;
      check("err_done", resp_valid, 0);
    end

    // Back-to-back with a stalled response consumer.
    resp_ready = 1'b0;
    drive(1'b1, 64'h10, 32'h12345678, 5'd9);
    tick;
    drive(1'b0, 64'h10, 32'h0, 5'd10);
    tick;
    for (int i = 0; i < 5; i++) begin
      check("stall_resp", {resp_valid, resp_write, 3'b0, resp_tag}, {2'b11, 3'b0, 5'd9});
      check("stall_ready", {req_ready, read_data_flag}, 0);
      tick;
    end
    resp_ready = 1'b1;
    tick;
    check("hs_valid", resp_valid, 0);
    check("hs_no_accept", read_data_flag, 0);
    check("hs_ready", req_ready, 1);
    tick; req_valid = 1'b0;
    check("b2b_rflag", read_data_flag, 1);
    check("b2b_addr", address_of_data, 2);
    tick; tick;
    check("b2b_rdata", resp_rdata, 64'h12345678);
    check("b2b_tag", resp_tag, 10);
    check("b2b_counts", {load_count, store_count}, {16'd2, 16'd2});
    tick;

    // Reset while a store sits in ISSUE: the write still lands.
    drive(1'b1, 64'h08, 32'hCAFEF00D, 5'd4);
    tick; req_valid = 1'b0;
    check("mid_wflag", write_data_flag, 1);
    check("mid_addr", address_of_data, 1);
    reset = 1'b1;
    tick;
    check("mid_rst_flags", {resp_valid, read_data_flag, write_data_flag, req_ready}, 0);
    check("mid_rst_addr", address_of_data, 0);
    check("mid_rst_wdata", data_to_write, 0);
    check("mid_rst_tag", resp_tag, 0);
    check("mid_rst_counts", {load_count, store_count}, 0);
    reset = 1'b0;
    drive(1'b0, 64'h08, 32'h0, 5'd6);
    tick; req_valid = 1'b0;
    tick; tick;
    check("mid_ld_valid", resp_valid, 1);
    check("mid_ld_rdata", resp_rdata, 64'h00000000CAFEF00D);
    check("mid_ld_count", load_count, 1);
    tick;

    // Counter wrap, observed on the 4-bit instance.
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 64'h20 + 64'(i * 8), 32'(i), 5'd1);
      tick; req_valid = 1'b0;
      tick; tick;
    end
    check("wrap_pre_w", w_store_count, 15);
    check("wrap_pre", store_count, 15);
    drive(1'b1, 64'h100, 32'h55, 5'd2);
    tick; req_valid = 1'b0;
    tick;
    check("wrap_w", w_store_count, 0);
    check("wrap_full", store_count, 16);
    check("wrap_w_resp", {w_resp_valid, w_resp_err, w_resp_write}, 3'b101);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
